// File: rtl/h80bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// h80bus_arbiter_if
// Bundles the two requester ports, the shared memory port and the arbiter
// status outputs of the h80bus arbiter.
//
// Modports
//   master : the arbiter's view. It takes the requester requests and the
//            memory responses, and drives the memory port, the read data and
//            stalls back to the requesters, the grant vector and timeout_err.
//   slave  : the surrounding system's view (requesters plus memory), i.e. the
//            mirror image of master.
//
// Signals (N = 0,1)
//   mN_ce_n, mN_addr, mN_cmd, mN_wdata : requester N request, active-low ce_n
//   mN_rdata, mN_wait_n                : read data and active-low stall to N
//   s_ce_n, s_addr, s_cmd, s_wdata     : memory request
//   s_rdata, s_wait_n                  : memory read data and active-low stall
//   gnt                                : one-hot grant, bit N = N owns the bus
//   timeout_err                        : one-cycle watchdog abort pulse
// ---------------------------------------------------------------------------
interface h80bus_arbiter_if #(
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_CMD_WIDTH  = 3,
    parameter int BUS_DATA_WIDTH = 16
);
    logic                      m0_ce_n;
    logic [BUS_ADDR_WIDTH-1:0] m0_addr;
    logic [BUS_CMD_WIDTH-1:0]  m0_cmd;
    logic [BUS_DATA_WIDTH-1:0] m0_wdata;
    logic [BUS_DATA_WIDTH-1:0] m0_rdata;
    logic                      m0_wait_n;

    logic                      m1_ce_n;
    logic [BUS_ADDR_WIDTH-1:0] m1_addr;
    logic [BUS_CMD_WIDTH-1:0]  m1_cmd;
    logic [BUS_DATA_WIDTH-1:0] m1_wdata;
    logic [BUS_DATA_WIDTH-1:0] m1_rdata;
    logic                      m1_wait_n;

    logic                      s_ce_n;
    logic [BUS_ADDR_WIDTH-1:0] s_addr;
    logic [BUS_CMD_WIDTH-1:0]  s_cmd;
    logic [BUS_DATA_WIDTH-1:0] s_wdata;
    logic [BUS_DATA_WIDTH-1:0] s_rdata;
    logic                      s_wait_n;

    logic [1:0]                gnt;
    logic                      timeout_err;

    modport master (
        input  m0_ce_n, m0_addr, m0_cmd, m0_wdata,
        input  m1_ce_n, m1_addr, m1_cmd, m1_wdata,
        input  s_rdata, s_wait_n,
        output m0_rdata, m0_wait_n,
        output m1_rdata, m1_wait_n,
        output s_ce_n, s_addr, s_cmd, s_wdata,
        output gnt, timeout_err
    );

    modport slave (
        output m0_ce_n, m0_addr, m0_cmd, m0_wdata,
        output m1_ce_n, m1_addr, m1_cmd, m1_wdata,
        output s_rdata, s_wait_n,
        input  m0_rdata, m0_wait_n,
        input  m1_rdata, m1_wait_n,
        input  s_ce_n, s_addr, s_cmd, s_wdata,
        input  gnt, timeout_err
    );
endinterface

// File: rtl/h80bus_arbiter.sv
// ---------------------------------------------------------------------------
// h80bus_arbiter
// Two-requester round-robin arbiter in front of a single h80bus memory.
// The granted requester is connected combinationally to the memory port;
// the other requester is stalled for as long as it requests.
//
// Ports
//   clk      : sole clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : h80bus_arbiter_if.master (requesters, memory port, gnt,
//              timeout_err)
//
// Parameters
//   BUS_ADDR_WIDTH / BUS_CMD_WIDTH / BUS_DATA_WIDTH : bus field widths
//   TIMEOUT_CYCLES : stall-cycle limit for the optional watchdog
//
// Build option
//   H80BUS_ARB_WATCHDOG_EN : when defined, a watchdog forces completion of a
//   transaction whose memory stall has lasted TIMEOUT_CYCLES cycles and pulses
//   timeout_err. When undefined, timeout_err is tied low and a permanently
//   low s_wait_n stalls the bus indefinitely.
//
// States
//   IDLE | nobody owns the bus, memory port parked (ce_n high, fields zero)
//   GNT0 | requester 0 owns the bus
//   GNT1 | requester 1 owns the bus
// ---------------------------------------------------------------------------
module h80bus_arbiter #(
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_CMD_WIDTH  = 3,
    parameter int BUS_DATA_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    h80bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_lg;          // last requester granted; 1 after reset so 0 wins first tie

    logic   w_req0;
    logic   w_req1;
    logic   w_cur_req;     // owner is still requesting
    logic   w_other_req;   // the non-owner is requesting
    logic   w_timeout;
    logic   w_done;        // owner's transaction completes on this edge

    // Round-robin pick: a tie goes to the requester that was not granted last.
    function automatic state_t f_arbitrate(input logic req0, input logic req1,
                                           input logic lg);
        state_t pick;
        if (req0 && req1) begin
            pick = lg ? GNT0 : GNT1;
        end else if (req0) begin
            pick = GNT0;
        end else if (req1) begin
            pick = GNT1;
        end else begin
            pick = IDLE;
        end
        return pick;
    endfunction

    assign w_req0 = ~bus.m0_ce_n;
    assign w_req1 = ~bus.m1_ce_n;

    always_comb begin
        w_cur_req   = 1'b0;
        w_other_req = 1'b0;
        case (r_state)
            GNT0: begin
                w_cur_req   = w_req0;
                w_other_req = w_req1;
            end
            GNT1: begin
                w_cur_req   = w_req1;
                w_other_req = w_req0;
            end
            default: begin
                w_cur_req   = 1'b0;
                w_other_req = 1'b0;
            end
        endcase
    end

    // A timeout counts as a completion: the owner is released exactly as if
    // the memory had answered.
    assign w_done = w_cur_req & (bus.s_wait_n | w_timeout);

`ifdef H80BUS_ARB_WATCHDOG_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                          $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic            w_stall;
    logic [WD_W-1:0] r_wd_cnt;

    // Counts consecutive owner cycles spent waiting on the memory. The cycle
    // in which the count has reached the limit is the forced-completion cycle.
    assign w_stall   = w_cur_req & ~bus.s_wait_n;
    assign w_timeout = w_stall && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wd_cnt <= '0;
        end else if (w_stall && !w_timeout) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end else begin
            r_wd_cnt <= '0;
        end
    end
`else
    logic w_unused_timeout_cfg;

    assign w_timeout            = 1'b0;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                w_next = f_arbitrate(w_req0, w_req1, r_lg);
            end
            GNT0, GNT1: begin
                if (!w_cur_req) begin
                    // Owner withdrew before completing: re-arbitrate with the
                    // current owner counted as last granted.
                    w_next = f_arbitrate(w_req0, w_req1, (r_state == GNT1));
                end else if (w_done && w_other_req) begin
                    w_next = (r_state == GNT0) ? GNT1 : GNT0;
                end else begin
                    w_next = r_state;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_lg    <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_next == GNT0) begin
                r_lg <= 1'b0;
            end else if (w_next == GNT1) begin
                r_lg <= 1'b1;
            end
        end
    end

    assign bus.gnt         = {(r_state == GNT1), (r_state == GNT0)};
    assign bus.timeout_err = w_timeout;

    // Bus steering. A requester that is not the owner sees its own ce_n echoed
    // on wait_n, so it stalls only while it is actually asking.
    always_comb begin
        bus.s_ce_n    = 1'b1;
        bus.s_addr    = '0;
        bus.s_cmd     = '0;
        bus.s_wdata   = '0;
        bus.m0_rdata  = '0;
        bus.m1_rdata  = '0;
        bus.m0_wait_n = bus.m0_ce_n;
        bus.m1_wait_n = bus.m1_ce_n;
        case (r_state)
            GNT0: begin
                bus.s_ce_n    = bus.m0_ce_n;
                bus.s_addr    = bus.m0_addr;
                bus.s_cmd     = bus.m0_cmd;
                bus.s_wdata   = bus.m0_wdata;
                bus.m0_wait_n = bus.s_wait_n | w_timeout;
                bus.m0_rdata  = w_timeout ? '0 : bus.s_rdata;
            end
            GNT1: begin
                bus.s_ce_n    = bus.m1_ce_n;
                bus.s_addr    = bus.m1_addr;
                bus.s_cmd     = bus.m1_cmd;
                bus.s_wdata   = bus.m1_wdata;
                bus.m1_wait_n = bus.s_wait_n | w_timeout;
                bus.m1_rdata  = w_timeout ? '0 : bus.s_rdata;
            end
            default: begin
                bus.s_ce_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_h80bus_arbiter.sv
module tb_h80bus_arbiter;

    localparam int AW = 16;
    localparam int CW = 3;
    localparam int DW = 16;
`ifdef H80BUS_ARB_WATCHDOG_EN
    localparam int TO = 4;
    localparam bit WD = 1'b1;
`else
    localparam int TO = 255;
    localparam bit WD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    h80bus_arbiter_if #(.BUS_ADDR_WIDTH(AW), .BUS_CMD_WIDTH(CW), .BUS_DATA_WIDTH(DW)) bus();

    h80bus_arbiter #(
        .BUS_ADDR_WIDTH(AW), .BUS_CMD_WIDTH(CW), .BUS_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ce0, input logic [15:0] a0, input logic [2:0] c0,
                         input logic [15:0] d0, input logic ce1, input logic [15:0] a1,
                         input logic [2:0] c1, input logic [15:0] d1,
                         input logic sw, input logic [15:0] srd);
        bus.m0_ce_n  = ce0; bus.m0_addr = a0; bus.m0_cmd = c0; bus.m0_wdata = d0;
        bus.m1_ce_n  = ce1; bus.m1_addr = a1; bus.m1_cmd = c1; bus.m1_wdata = d1;
        bus.s_wait_n = sw;  bus.s_rdata = srd;
    endtask

    // ---------------- behavioural reference model ----------------
    // owner: -1 nobody, 0 or 1 requester index
    int m_owner = -1;
    int m_lg    = 1;
    int m_stall = 0;

    task automatic m_reset();
        m_owner = -1;
        m_lg    = 1;
        m_stall = 0;
    endtask

    function automatic bit m_req(input int n);
        return (n == 0) ? !bus.m0_ce_n : !bus.m1_ce_n;
    endfunction

    function automatic int m_pick(input int lg);
        if (m_req(0) && m_req(1)) return 1 - lg;
        if (m_req(0)) return 0;
        if (m_req(1)) return 1;
        return -1;
    endfunction

    function automatic bit m_timeout();
        if (!WD || m_owner < 0) return 1'b0;
        return m_req(m_owner) && !bus.s_wait_n && (m_stall == TO);
    endfunction

    task automatic model_check(input string tag);
        logic [1:0]  e_gnt;
        logic        e_sce;
        logic [15:0] e_sa, e_sd, e_r0, e_r1;
        logic [2:0]  e_sc;
        logic        e_w0, e_w1;
        bit          to;
        to    = m_timeout();
        e_gnt = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
        e_sce = 1'b1; e_sa = '0; e_sc = '0; e_sd = '0;
        e_w0  = bus.m0_ce_n; e_r0 = '0;
        e_w1  = bus.m1_ce_n; e_r1 = '0;
        if (m_owner == 0) begin
            e_sce = bus.m0_ce_n; e_sa = bus.m0_addr; e_sc = bus.m0_cmd; e_sd = bus.m0_wdata;
            e_w0  = to ? 1'b1 : bus.s_wait_n;
            e_r0  = to ? 16'h0 : bus.s_rdata;
        end else if (m_owner == 1) begin
            e_sce = bus.m1_ce_n; e_sa = bus.m1_addr; e_sc = bus.m1_cmd; e_sd = bus.m1_wdata;
            e_w1  = to ? 1'b1 : bus.s_wait_n;
            e_r1  = to ? 16'h0 : bus.s_rdata;
        end
        check({tag, " gnt"},         32'(bus.gnt),         32'(e_gnt));
        check({tag, " s_ce_n"},      32'(bus.s_ce_n),      32'(e_sce));
        check({tag, " s_addr"},      32'(bus.s_addr),      32'(e_sa));
        check({tag, " s_cmd"},       32'(bus.s_cmd),       32'(e_sc));
        check({tag, " s_wdata"},     32'(bus.s_wdata),     32'(e_sd));
        check({tag, " m0_wait_n"},   32'(bus.m0_wait_n),   32'(e_w0));
        check({tag, " m1_wait_n"},   32'(bus.m1_wait_n),   32'(e_w1));
        check({tag, " m0_rdata"},    32'(bus.m0_rdata),    32'(e_r0));
        check({tag, " m1_rdata"},    32'(bus.m1_rdata),    32'(e_r1));
        check({tag, " timeout_err"}, 32'(bus.timeout_err), 32'(to));
    endtask

    task automatic model_step();
        int  o;
        int  no;
        int  st;
        bit  to;
        o  = m_owner;
        to = m_timeout();
        st = 0;
        if (o >= 0 && m_req(o) && !bus.s_wait_n && !to) st = m_stall + 1;
        if (o < 0)                          no = m_pick(m_lg);
        else if (!m_req(o))                 no = m_pick(o);
        else if (bus.s_wait_n || to)        no = m_req(1 - o) ? 1 - o : o;
        else                                no = o;
        if (no >= 0) m_lg = no;
        m_owner = no;
        m_stall = st;
    endtask

    // Inputs are driven at the falling edge; tick checks mid-phase, advances
    // the model at the rising edge and returns at the next falling edge.
    task automatic tick(input string tag);
        #1;
        model_check(tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b1, 16'h0, 3'd0, 16'h0, 1'b1, 16'h0, 3'd0, 16'h0, 1'b1, 16'h0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic        ce0; logic [15:0] a0; logic [2:0] c0; logic [15:0] d0;
        logic        ce1; logic [15:0] a1; logic [2:0] c1; logic [15:0] d1;
        logic        sw;  logic [15:0] srd;
        logic [1:0]  e_gnt; logic e_sce; logic [15:0] e_sa; logic [15:0] e_sd;
        logic        e_w0;  logic e_w1;  logic [15:0] e_r0; logic [15:0] e_r1;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    initial begin
        #1_000_000;
        $display("FAIL global time limit expired");
        $fatal(1, "time limit");
    end

    initial begin
        // rst ce0 a0 c0 d0 | ce1 a1 c1 d1 | sw srd | gnt sce sa sd w0 w1 r0 r1
        tbl[0]  = '{1'b1, 1'b1,16'h0000,3'd0,16'h0000, 1'b1,16'h0000,3'd0,16'h0000, 1'b1,16'hAAAA, 2'b00,1'b1,16'h0000,16'h0000, 1'b1,1'b1,16'h0000,16'h0000};
        tbl[1]  = '{1'b0, 1'b0,16'h0010,3'd1,16'h0000, 1'b1,16'h0000,3'd0,16'h0000, 1'b1,16'hBEEF, 2'b00,1'b1,16'h0000,16'h0000, 1'b0,1'b1,16'h0000,16'h0000};
        tbl[2]  = '{1'b0, 1'b0,16'h0010,3'd1,16'h0000, 1'b1,16'h0000,3'd0,16'h0000, 1'b1,16'hBEEF, 2'b01,1'b0,16'h0010,16'h0000, 1'b1,1'b1,16'hBEEF,16'h0000};
        tbl[3]  = '{1'b0, 1'b1,16'h0010,3'd1,16'h0000, 1'b1,16'h0000,3'd0,16'h0000, 1'b1,16'hBEEF, 2'b01,1'b1,16'h0010,16'h0000, 1'b1,1'b1,16'hBEEF,16'h0000};
        tbl[4]  = '{1'b1, 1'b0,16'h0100,3'd1,16'h0000, 1'b0,16'h0200,3'd1,16'h0000, 1'b1,16'h1111, 2'b00,1'b1,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000};
        tbl[5]  = '{1'b0, 1'b0,16'h0100,3'd1,16'h0000, 1'b0,16'h0200,3'd1,16'h0000, 1'b1,16'h1111, 2'b01,1'b0,16'h0100,16'h0000, 1'b1,1'b0,16'h1111,16'h0000};
        tbl[6]  = '{1'b0, 1'b1,16'h0100,3'd1,16'h0000, 1'b0,16'h0200,3'd1,16'h0000, 1'b1,16'h2222, 2'b10,1'b0,16'h0200,16'h0000, 1'b1,1'b1,16'h0000,16'h2222};
        tbl[7]  = '{1'b0, 1'b1,16'h0100,3'd1,16'h0000, 1'b1,16'h0200,3'd1,16'h0000, 1'b1,16'h2222, 2'b10,1'b1,16'h0200,16'h0000, 1'b1,1'b1,16'h0000,16'h2222};
        tbl[8]  = '{1'b0, 1'b1,16'h0000,3'd0,16'h0000, 1'b0,16'h0300,3'd0,16'h1234, 1'b1,16'h3333, 2'b00,1'b1,16'h0000,16'h0000, 1'b1,1'b0,16'h0000,16'h0000};
        tbl[9]  = '{1'b0, 1'b1,16'h0000,3'd0,16'h0000, 1'b0,16'h0300,3'd0,16'h1234, 1'b1,16'h3333, 2'b10,1'b0,16'h0300,16'h1234, 1'b1,1'b1,16'h0000,16'h3333};
        tbl[10] = '{1'b0, 1'b1,16'h0000,3'd0,16'h0000, 1'b0,16'h0302,3'd0,16'h5678, 1'b1,16'h3333, 2'b10,1'b0,16'h0302,16'h5678, 1'b1,1'b1,16'h0000,16'h3333};
        tbl[11] = '{1'b0, 1'b1,16'h0000,3'd0,16'h0000, 1'b0,16'h0304,3'd0,16'h9ABC, 1'b1,16'h3333, 2'b10,1'b0,16'h0304,16'h9ABC, 1'b1,1'b1,16'h0000,16'h3333};
        tbl[12] = '{1'b0, 1'b1,16'h0000,3'd0,16'h0000, 1'b1,16'h0304,3'd0,16'h9ABC, 1'b1,16'h3333, 2'b10,1'b1,16'h0304,16'h9ABC, 1'b1,1'b1,16'h0000,16'h3333};
        tbl[13] = '{1'b0, 1'b1,16'h0000,3'd0,16'h0000, 1'b1,16'h0000,3'd0,16'h0000, 1'b1,16'h4444, 2'b00,1'b1,16'h0000,16'h0000, 1'b1,1'b1,16'h0000,16'h0000};
        tbl[14] = '{1'b0, 1'b0,16'h0400,3'd1,16'h0000, 1'b1,16'h0000,3'd0,16'h0000, 1'b0,16'h5555, 2'b00,1'b1,16'h0000,16'h0000, 1'b0,1'b1,16'h0000,16'h0000};
        tbl[15] = '{1'b0, 1'b0,16'h0400,3'd1,16'h0000, 1'b1,16'h0000,3'd0,16'h0000, 1'b0,16'h5555, 2'b01,1'b0,16'h0400,16'h0000, 1'b0,1'b1,16'h5555,16'h0000};
        tbl[16] = '{1'b0, 1'b0,16'h0400,3'd1,16'h0000, 1'b1,16'h0000,3'd0,16'h0000, 1'b1,16'h5555, 2'b01,1'b0,16'h0400,16'h0000, 1'b1,1'b1,16'h5555,16'h0000};
        tbl[17] = '{1'b0, 1'b1,16'h0400,3'd1,16'h0000, 1'b1,16'h0000,3'd0,16'h0000, 1'b1,16'h5555, 2'b01,1'b1,16'h0400,16'h0000, 1'b1,1'b1,16'h5555,16'h0000};

        drive(1'b1, 16'h0, 3'd0, 16'h0, 1'b1, 16'h0, 3'd0, 16'h0, 1'b1, 16'h0);
        #2;
        check("reset gnt",         32'(bus.gnt),         32'h0);
        check("reset s_ce_n",      32'(bus.s_ce_n),      32'h1);
        check("reset timeout_err", 32'(bus.timeout_err), 32'h0);
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].rst) do_reset();
            drive(tbl[i].ce0, tbl[i].a0, tbl[i].c0, tbl[i].d0,
                  tbl[i].ce1, tbl[i].a1, tbl[i].c1, tbl[i].d1, tbl[i].sw, tbl[i].srd);
            #1;
            check($sformatf("tbl%0d gnt", i),         32'(bus.gnt),         32'(tbl[i].e_gnt));
            check($sformatf("tbl%0d s_ce_n", i),      32'(bus.s_ce_n),      32'(tbl[i].e_sce));
            check($sformatf("tbl%0d s_addr", i),      32'(bus.s_addr),      32'(tbl[i].e_sa));
            check($sformatf("tbl%0d s_wdata", i),     32'(bus.s_wdata),     32'(tbl[i].e_sd));
            check($sformatf("tbl%0d m0_wait_n", i),   32'(bus.m0_wait_n),   32'(tbl[i].e_w0));
            check($sformatf("tbl%0d m1_wait_n", i),   32'(bus.m1_wait_n),   32'(tbl[i].e_w1));
            check($sformatf("tbl%0d m0_rdata", i),    32'(bus.m0_rdata),    32'(tbl[i].e_r0));
            check($sformatf("tbl%0d m1_rdata", i),    32'(bus.m1_rdata),    32'(tbl[i].e_r1));
            check($sformatf("tbl%0d timeout_err", i), 32'(bus.timeout_err), 32'h0);
            @(posedge clk);
            @(negedge clk);
        end

        // Fairness: both request continuously, grants alternate per completion.
        do_reset();
        drive(1'b0, 16'h0A00, 3'd1, 16'h0, 1'b0, 16'h0B00, 3'd1, 16'h0, 1'b1, 16'h7777);
        tick("fair idle");
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("fair gnt%0d", k), 32'(bus.gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick("fair");
        end
        drive(1'b1, 16'h0, 3'd0, 16'h0, 1'b1, 16'h0, 3'd0, 16'h0, 1'b1, 16'h0);
        tick("fair end");
        tick("fair end");

        // Reset asserted mid-transaction while the memory stalls.
        do_reset();
        drive(1'b1, 16'h0, 3'd0, 16'h0, 1'b0, 16'h0C00, 3'd1, 16'h0, 1'b0, 16'h0);
        tick("rst idle");
        #1;
        check("rst pre gnt",    32'(bus.gnt),    32'h2);
        check("rst pre s_ce_n", 32'(bus.s_ce_n), 32'h0);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst async gnt",       32'(bus.gnt),         32'h0);
        check("rst async s_ce_n",    32'(bus.s_ce_n),      32'h1);
        check("rst async m1_wait_n", 32'(bus.m1_wait_n),   32'h0);
        check("rst async terr",      32'(bus.timeout_err), 32'h0);
        reset_n = 1'b1;
        m_reset();
        drive(1'b0, 16'h0D00, 3'd1, 16'h0, 1'b1, 16'h0, 3'd0, 16'h0, 1'b1, 16'h2468);
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
        check("rst after gnt", 32'(bus.gnt), 32'h1);
        tick("rst after");
        drive(1'b1, 16'h0, 3'd0, 16'h0, 1'b1, 16'h0, 3'd0, 16'h0, 1'b1, 16'h0);
        tick("rst after");

        // Permanently stalled memory.
        do_reset();
        drive(1'b0, 16'h0E00, 3'd1, 16'h0, 1'b1, 16'h0, 3'd0, 16'h0, 1'b0, 16'h5A5A);
        tick("wd idle");
`ifdef H80BUS_ARB_WATCHDOG_EN
        for (int k = 0; k < TO; k++) begin
            #1;
            check("wd stall terr",      32'(bus.timeout_err), 32'h0);
            check("wd stall m0_wait_n", 32'(bus.m0_wait_n),   32'h0);
            tick("wd stall");
        end
        #1;
        check("wd fire terr",      32'(bus.timeout_err), 32'h1);
        check("wd fire m0_wait_n", 32'(bus.m0_wait_n),   32'h1);
        check("wd fire m0_rdata",  32'(bus.m0_rdata),    32'h0);
        tick("wd fire");
        drive(1'b1, 16'h0E00, 3'd1, 16'h0, 1'b1, 16'h0, 3'd0, 16'h0, 1'b0, 16'h5A5A);
        #1;
        check("wd after terr", 32'(bus.timeout_err), 32'h0);
        tick("wd after");
        #1;
        check("wd idle gnt", 32'(bus.gnt), 32'h0);
        tick("wd idle2");
`else
        for (int k = 0; k < 20; k++) begin
            #1;
            check("nowd m0_wait_n", 32'(bus.m0_wait_n),   32'h0);
            check("nowd terr",      32'(bus.timeout_err), 32'h0);
            check("nowd gnt",       32'(bus.gnt),         32'h1);
            tick("nowd stall");
        end
        drive(1'b1, 16'h0, 3'd0, 16'h0, 1'b1, 16'h0, 3'd0, 16'h0, 1'b1, 16'h0);
        tick("nowd end");
`endif

        // Randomized traffic against the reference model.
        do_reset();
        begin
            int burst;
            logic sw;
            burst = 0;
            for (int n = 0; n < 3000; n++) begin
                if (burst > 0) begin
                    sw = 1'b0;
                    burst--;
                end else begin
                    sw = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 99) == 0) burst = 8;
                end
                drive(($urandom_range(0, 3) == 0), 16'($urandom), 3'($urandom), 16'($urandom),
                      ($urandom_range(0, 3) == 0), 16'($urandom), 3'($urandom), 16'($urandom),
                      sw, 16'($urandom));
                tick("rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
